// File: rtl/ball_physics.sv
// Pong ball engine: steps the square on a prescaled tick, reflects it off walls
// and paddles, scores misses and sequences the serve / game-over flow.
module ball_physics #(
  parameter int CLK_HZ      = 25_175_000,
  parameter int H_VIDEO     = 640,
  parameter int V_VIDEO     = 480,
  parameter int SQ_SIZE     = 12,
  parameter int PDL_WIDTH   = 8,
  parameter int PDL_HEIGHT  = 96,
  parameter int BALL_SPEED  = 300,
  parameter int SERVE_DELAY = 25_175_000,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       reset_game,
  input  logic       game_active,
  input  logic [9:0] p1_xpos,
  input  logic [9:0] p1_ypos,
  input  logic [9:0] p2_xpos,
  input  logic [9:0] p2_ypos,
  output logic [9:0] sq_xpos,
  output logic [9:0] sq_ypos,
  output logic       sq_xveldir,
  output logic       sq_yveldir,
  output logic       sq_missed,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over
);

  localparam int PSC_LIMIT = CLK_HZ / BALL_SPEED;
  localparam int PSC_W     = $clog2(PSC_LIMIT + 2);
  localparam int DLY_W     = $clog2(SERVE_DELAY + 1);

  localparam logic [9:0]       CX       = 10'((H_VIDEO - SQ_SIZE) / 2);
  localparam logic [9:0]       CY       = 10'((V_VIDEO - SQ_SIZE) / 2);
  localparam logic [10:0]      SQ11     = 11'(SQ_SIZE);
  localparam logic [10:0]      H11      = 11'(H_VIDEO);
  localparam logic [10:0]      V11      = 11'(V_VIDEO);
  localparam logic [10:0]      PW11     = 11'(PDL_WIDTH);
  localparam logic [10:0]      PH11     = 11'(PDL_HEIGHT);
  localparam logic [PSC_W-1:0] PSC_MAX  = PSC_W'(PSC_LIMIT);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SERVE_DELAY - 1);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             xdir_q, xdir_d, ydir_q, ydir_d;
  logic             missed_q, missed_d, over_q, over_d;
  logic             serve_dir_q, serve_dir_d;
  logic [3:0]       s1_q, s1_d, s2_q, s2_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [DLY_W-1:0] dly_q, dly_d;

  // All geometry is done at 11 bits so edge sums never wrap.
  logic [10:0] x_ext, y_ext, x_right, y_bot, p1_face;
  logic        ov1, ov2, tick, miss_l, miss_r, hit_l, hit_r, wall_t, wall_b;
  logic [3:0]  last_score;

  assign x_ext   = {1'b0, x_q};
  assign y_ext   = {1'b0, y_q};
  assign x_right = x_ext + SQ11;
  assign y_bot   = y_ext + SQ11;
  assign p1_face = {1'b0, p1_xpos} + PW11;
  assign ov1     = (y_bot > {1'b0, p1_ypos}) && (y_ext < ({1'b0, p1_ypos} + PH11));
  assign ov2     = (y_bot > {1'b0, p2_ypos}) && (y_ext < ({1'b0, p2_ypos} + PH11));
  assign tick    = (psc_q == PSC_MAX);
  assign miss_l  = !xdir_q && (x_q == 10'd0);
  assign miss_r  = xdir_q && (x_right == H11);
  assign hit_l   = !xdir_q && (x_ext == p1_face) && ov1;
  assign hit_r   = xdir_q && (x_right == {1'b0, p2_xpos}) && ov2;
  assign wall_t  = !ydir_q && (y_q == 10'd0);
  assign wall_b  = ydir_q && (y_bot == V11);
  // serve_dir records who scored last, so it also selects the score to test for a win.
  assign last_score = serve_dir_q ? s1_q : s2_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    xdir_d      = xdir_q;
    ydir_d      = ydir_q;
    missed_d    = 1'b0;
    over_d      = over_q;
    serve_dir_d = serve_dir_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    psc_d       = psc_q;
    dly_d       = dly_q;

    if (reset_game) begin
      state_d     = S_IDLE;
      x_d         = CX;
      y_d         = CY;
      ydir_d      = 1'b1;
      over_d      = 1'b0;
      serve_dir_d = 1'b1;
      s1_d        = 4'd0;
      s2_d        = 4'd0;
      psc_d       = '0;
      dly_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          x_d = CX;
          y_d = CY;
          if (game_active) begin
            state_d = S_SERVE;
            dly_d   = '0;
          end
        end
        S_SERVE: begin
          x_d = CX;
          y_d = CY;
          if (!game_active) begin
            state_d = S_IDLE;
          end else if (dly_q == DLY_LAST) begin
            state_d = S_PLAY;
            psc_d   = '0;
            dly_d   = '0;
            xdir_d  = serve_dir_q;
            ydir_d  = ~ydir_q;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (!game_active) begin
            state_d = S_IDLE;
            x_d     = CX;
            y_d     = CY;
          end else if (!tick) begin
            psc_d = psc_q + 1'b1;
          end else begin
            psc_d = '0;
            if (miss_l) begin
              state_d     = S_MISS;
              s2_d        = sat_inc(s2_q);
              serve_dir_d = 1'b0;
              missed_d    = 1'b1;
            end else if (miss_r) begin
              state_d     = S_MISS;
              s1_d        = sat_inc(s1_q);
              serve_dir_d = 1'b1;
              missed_d    = 1'b1;
            end else begin
              if (hit_l) begin
                xdir_d = 1'b1;
                x_d    = x_q + 10'd1;
              end else if (hit_r) begin
                xdir_d = 1'b0;
                x_d    = x_q - 10'd1;
              end else begin
                x_d = xdir_q ? x_q + 10'd1 : x_q - 10'd1;
              end
              if (wall_t) begin
                ydir_d = 1'b1;
                y_d    = y_q + 10'd1;
              end else if (wall_b) begin
                ydir_d = 1'b0;
                y_d    = y_q - 10'd1;
              end else begin
                y_d = ydir_q ? y_q + 10'd1 : y_q - 10'd1;
              end
            end
          end
        end
        S_MISS: begin
          x_d = CX;
          y_d = CY;
          if (last_score == WIN) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_SERVE;
            dly_d   = '0;
          end
        end
        S_OVER: begin
          x_d = CX;
          y_d = CY;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      x_q         <= CX;
      y_q         <= CY;
      xdir_q      <= 1'b1;
      ydir_q      <= 1'b1;
      missed_q    <= 1'b0;
      over_q      <= 1'b0;
      serve_dir_q <= 1'b1;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      psc_q       <= '0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xdir_q      <= xdir_d;
      ydir_q      <= ydir_d;
      missed_q    <= missed_d;
      over_q      <= over_d;
      serve_dir_q <= serve_dir_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      psc_q       <= psc_d;
      dly_q       <= dly_d;
    end
  end

  assign sq_xpos    = x_q;
  assign sq_ypos    = y_q;
  assign sq_xveldir = xdir_q;
  assign sq_yveldir = ydir_q;
  assign sq_missed  = missed_q;
  assign score_p1   = s1_q;
  assign score_p2   = s2_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: vector table, scripted rallies with hand-derived
// positions, then random play checked every cycle against a rule-level model.
module tb_ball_physics;

  localparam int CLK_HZ      = 100;
  localparam int BALL_SPEED  = 25;
  localparam int SERVE_DELAY = 10;
  localparam int PSC = CLK_HZ / BALL_SPEED;
  localparam int CX = 314, CY = 234, SQ = 12, HV = 640, VV = 480, PW = 8, PH = 96, WIN = 7;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3, M_OVER = 4;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0, reset_game = 1'b0, game_active = 1'b0;
  logic [9:0] p1_xpos = 10'd24, p1_ypos = 10'd200, p2_xpos = 10'd620, p2_ypos = 10'd0;
  logic [9:0] sq_xpos, sq_ypos;
  logic       sq_xveldir, sq_yveldir, sq_missed, game_over;
  logic [3:0] score_p1, score_p2;

  int n_pass = 0, n_total = 0;

  // Reference model: plain integers, one countdown per timed phase.
  int m_mode, m_x, m_y, m_s1, m_s2, m_wait, m_to_tick, m_last;
  bit m_dx, m_dy, m_missed, m_over, m_serve_right;

  typedef struct {
    bit    rst_n;
    bit    ga;
    bit    rg;
    int    cycles;
    int    ex, ey, exd, eyd, es1, es2, ego;
    string name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk_0 = ~clk_0;

  ball_physics #(
    .CLK_HZ(CLK_HZ), .BALL_SPEED(BALL_SPEED), .SERVE_DELAY(SERVE_DELAY)
  ) dut (
    .clk_0(clk_0), .rst(rst), .reset_game(reset_game), .game_active(game_active),
    .p1_xpos(p1_xpos), .p1_ypos(p1_ypos), .p2_xpos(p2_xpos), .p2_ypos(p2_ypos),
    .sq_xpos(sq_xpos), .sq_ypos(sq_ypos), .sq_xveldir(sq_xveldir), .sq_yveldir(sq_yveldir),
    .sq_missed(sq_missed), .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit overlaps(input int y, input int py);
    return (y + SQ > py) && (y < py + PH);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_missed = 0;
    m_s1 = 0; m_s2 = 0; m_over = 0; m_serve_right = 1; m_wait = 0; m_to_tick = 0; m_last = 1;
  endtask

  task automatic model_tick();
    if (!m_dx && m_x == 0) begin
      m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_serve_right = 0; m_last = 2;
      m_mode = M_MISS; m_missed = 1;
    end else if (m_dx && m_x + SQ == HV) begin
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_serve_right = 1; m_last = 1;
      m_mode = M_MISS; m_missed = 1;
    end else begin
      if (!m_dx && m_x == int'(p1_xpos) + PW && overlaps(m_y, int'(p1_ypos))) begin
        m_dx = 1; m_x = m_x + 1;
      end else if (m_dx && m_x + SQ == int'(p2_xpos) && overlaps(m_y, int'(p2_ypos))) begin
        m_dx = 0; m_x = m_x - 1;
      end else begin
        m_x = m_dx ? m_x + 1 : m_x - 1;
      end
      if (!m_dy && m_y == 0) begin
        m_dy = 1; m_y = 1;
      end else if (m_dy && m_y + SQ == VV) begin
        m_dy = 0; m_y = m_y - 1;
      end else begin
        m_y = m_dy ? m_y + 1 : m_y - 1;
      end
    end
  endtask

  task automatic model_edge();
    m_missed = 0;
    if (!rst) begin
      model_reset();
    end else if (reset_game) begin
      m_mode = M_IDLE; m_x = CX; m_y = CY; m_dy = 1; m_s1 = 0; m_s2 = 0;
      m_over = 0; m_serve_right = 1;
    end else begin
      case (m_mode)
        M_IDLE: if (game_active) begin m_mode = M_SERVE; m_wait = SERVE_DELAY; end
        M_SERVE: begin
          if (!game_active) m_mode = M_IDLE;
          else begin
            m_wait--;
            if (m_wait == 0) begin
              m_mode = M_PLAY; m_dx = m_serve_right; m_dy = !m_dy; m_to_tick = PSC + 1;
            end
          end
        end
        M_PLAY: begin
          if (!game_active) begin
            m_mode = M_IDLE; m_x = CX; m_y = CY;
          end else begin
            m_to_tick--;
            if (m_to_tick == 0) begin
              m_to_tick = PSC + 1;
              model_tick();
            end
          end
        end
        M_MISS: begin
          m_x = CX; m_y = CY;
          if ((m_last == 1 ? m_s1 : m_s2) == WIN) begin m_mode = M_OVER; m_over = 1; end
          else begin m_mode = M_SERVE; m_wait = SERVE_DELAY; end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, compare after it.
  task automatic step();
    logic [31:0] dv, mv;
    @(posedge clk_0);
    model_edge();
    #1;
    dv = {sq_xpos, sq_ypos, sq_xveldir, sq_yveldir, sq_missed, score_p1, score_p2, game_over};
    mv = {10'(m_x), 10'(m_y), m_dx, m_dy, m_missed, 4'(m_s1), 4'(m_s2), m_over};
    n_total++;
    if (dv == mv) n_pass++;
    else $display("FAIL model: t=%0t got %h, expected %h", $time, dv, mv);
  endtask

  function automatic bit ev(input int sel, input int val, input int x0, input int y0);
    case (sel)
      0:       return int'(sq_xpos) == val;
      1:       return int'(sq_ypos) == val;
      2:       return sq_missed == 1'b1;
      default: return (int'(sq_xpos) != x0) || (int'(sq_ypos) != y0);
    endcase
  endfunction

  // sel: 0 x==val, 1 y==val, 2 miss pulse, 3 ball moved.
  task automatic wait_for(input int sel, input int val, input int bound, input string name);
    int n = 0;
    int x0 = int'(sq_xpos);
    int y0 = int'(sq_ypos);
    while (!ev(sel, val, x0, y0) && n < bound) begin
      step();
      n++;
    end
    n_total++;
    if (ev(sel, val, x0, y0)) n_pass++;
    else $display("FAIL %s: event not seen within %0d cycles", name, bound);
  endtask

  task automatic add_vec(input bit r, input bit ga, input bit rg, input int cyc, input int ex,
                         input int ey, input int exd, input int eyd, input string name);
    vec_t v;
    v.rst_n = r; v.ga = ga; v.rg = rg; v.cycles = cyc; v.ex = ex; v.ey = ey;
    v.exd = exd; v.eyd = eyd; v.es1 = 0; v.es2 = 0; v.ego = 0; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    model_reset();
    add_vec(0, 0, 0, 2,  314, 234, 1, 1, "reset");
    add_vec(1, 0, 0, 3,  314, 234, 1, 1, "idle");
    add_vec(1, 1, 0, 1,  314, 234, 1, 1, "serve_enter");
    add_vec(1, 1, 0, 10, 314, 234, 1, 0, "serve_done");
    add_vec(1, 1, 0, 4,  314, 234, 1, 0, "pre_tick");
    add_vec(1, 1, 0, 1,  315, 233, 1, 0, "first_tick");
    add_vec(1, 1, 0, 5,  316, 232, 1, 0, "second_tick");
    add_vec(1, 0, 0, 1,  314, 234, 1, 0, "ga_drop");
    add_vec(1, 1, 1, 1,  314, 234, 1, 1, "reset_game");
    add_vec(1, 0, 0, 2,  314, 234, 1, 1, "idle_again");

    foreach (vecs[i]) begin
      rst = vecs[i].rst_n; game_active = vecs[i].ga; reset_game = vecs[i].rg;
      for (int c = 0; c < vecs[i].cycles; c++) step();
      chk({vecs[i].name, "_x"}, sq_xpos, vecs[i].ex);
      chk({vecs[i].name, "_y"}, sq_ypos, vecs[i].ey);
      chk({vecs[i].name, "_xd"}, sq_xveldir, vecs[i].exd);
      chk({vecs[i].name, "_yd"}, sq_yveldir, vecs[i].eyd);
      chk({vecs[i].name, "_s1"}, score_p1, vecs[i].es1);
      chk({vecs[i].name, "_s2"}, score_p2, vecs[i].es2);
      chk({vecs[i].name, "_go"}, game_over, vecs[i].ego);
      $display("vec %s: x=%0d y=%0d xd=%0d yd=%0d", vecs[i].name, sq_xpos, sq_ypos,
               sq_xveldir, sq_yveldir);
    end

    // Rally 1: serve right/up, top wall, right paddle hit, bottom wall, miss past p1.
    game_active = 1;
    wait_for(1, 0, 3000, "reach_top");
    chk("top_x", sq_xpos, 548); chk("top_yd", sq_yveldir, 0);
    wait_for(3, 0, 10, "top_move");
    chk("top_bounce_y", sq_ypos, 1); chk("top_bounce_yd", sq_yveldir, 1);
    wait_for(0, 608, 2000, "reach_p2");
    chk("p2_face_y", sq_ypos, 60);
    wait_for(3, 0, 10, "p2_move");
    chk("p2_hit_x", sq_xpos, 607); chk("p2_hit_xd", sq_xveldir, 0); chk("p2_hit_y", sq_ypos, 61);
    wait_for(1, 468, 5000, "reach_bottom");
    chk("bottom_x", sq_xpos, 200);
    wait_for(3, 0, 10, "bottom_move");
    chk("bottom_y", sq_ypos, 467); chk("bottom_yd", sq_yveldir, 0);
    wait_for(0, 32, 5000, "reach_p1_nohit");
    chk("p1_edge_y", sq_ypos, 300);
    wait_for(3, 0, 10, "p1_nohit_move");
    chk("p1_nohit_x", sq_xpos, 31); chk("p1_nohit_xd", sq_xveldir, 0);
    p1_ypos = 10'd380;
    wait_for(2, 0, 2000, "left_miss");
    chk("lmiss_x", sq_xpos, 0); chk("lmiss_y", sq_ypos, 268);
    chk("lmiss_s2", score_p2, 1); chk("lmiss_s1", score_p1, 0);
    step();
    chk("lmiss_pulse_end", sq_missed, 0); chk("lmiss_cx", sq_xpos, 314); chk("lmiss_cy", sq_ypos, 234);
    for (int c = 0; c < 10; c++) step();
    chk("serve2_xd", sq_xveldir, 0); chk("serve2_yd", sq_yveldir, 1);

    // Rally 2: left paddle hit, then a right miss under a paddle parked at the top.
    wait_for(0, 32, 3000, "reach_p1_hit");
    chk("p1_hit_pre_y", sq_ypos, 420);
    wait_for(3, 0, 10, "p1_hit_move");
    chk("p1_hit_x", sq_xpos, 33); chk("p1_hit_xd", sq_xveldir, 1); chk("p1_hit_y", sq_ypos, 419);
    wait_for(2, 0, 5000, "right_miss");
    chk("rmiss_x", sq_xpos, 628); chk("rmiss_y", sq_ypos, 176);
    chk("rmiss_s1", score_p1, 1); chk("rmiss_s2", score_p2, 1);
    step();
    chk("rmiss_pulse_end", sq_missed, 0); chk("rmiss_cx", sq_xpos, 314);
    p2_xpos = 10'd560;
    for (int c = 0; c < 10; c++) step();
    chk("serve3_xd", sq_xveldir, 1); chk("serve3_yd", sq_yveldir, 0);

    // Rally 3: paddle face and top wall on the same tick.
    wait_for(0, 548, 3000, "reach_corner");
    chk("corner_pre_y", sq_ypos, 0);
    wait_for(3, 0, 10, "corner_move");
    chk("corner_x", sq_xpos, 547); chk("corner_y", sq_ypos, 1);
    chk("corner_xd", sq_xveldir, 0); chk("corner_yd", sq_yveldir, 1);

    // Asynchronous reset between clock edges.
    step(); step();
    #2 rst = 0;
    model_reset();
    #1;
    chk("arst_x", sq_xpos, 314); chk("arst_y", sq_ypos, 234);
    chk("arst_xd", sq_xveldir, 1); chk("arst_yd", sq_yveldir, 1);
    chk("arst_miss", sq_missed, 0); chk("arst_s1", score_p1, 0);
    chk("arst_s2", score_p2, 0); chk("arst_go", game_over, 0);
    step();
    rst = 1;

    // Game over: p1 can never block, so p2 scores until the win.
    p1_ypos = 10'd600; p2_xpos = 10'd620; p2_ypos = 10'd0;
    for (int i = 1; i <= 7; i++) begin
      wait_for(2, 0, 8000, "p2_point");
      chk("gover_s2", score_p2, i); chk("gover_s1", score_p1, 0);
      if (i == 7) chk("gover_not_yet", game_over, 0);
      step();
    end
    chk("gover_flag", game_over, 1); chk("gover_cx", sq_xpos, 314); chk("gover_cy", sq_ypos, 234);
    for (int c = 0; c < 20; c++) step();
    chk("gover_hold", game_over, 1); chk("gover_frozen_x", sq_xpos, 314);
    reset_game = 1;
    step();
    reset_game = 0;
    chk("rg_s1", score_p1, 0); chk("rg_s2", score_p2, 0);
    chk("rg_go", game_over, 0); chk("rg_yd", sq_yveldir, 1);
    $display("scripted rallies done: %0d checks so far", n_total);

    // Random play: moving paddles, occasional mode drops, game resets and hard resets.
    for (int c = 0; c < 15000; c++) begin
      if (c % 200 == 0) begin
        p1_xpos = 10'($urandom_range(0, 60));
        p1_ypos = 10'($urandom_range(0, 479));
        p2_xpos = 10'($urandom_range(560, 639));
        p2_ypos = 10'($urandom_range(0, 479));
      end
      game_active = ($urandom_range(0, 1999) != 0);
      reset_game  = ($urandom_range(0, 4999) == 0);
      rst         = ($urandom_range(0, 7999) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
